// File: rtl/dram_pad_responder.sv
// dram_pad_responder: DRAM-side end of the memory pad interface.
// Decodes DDR3 commands from the pad pins and captures BL8 write bursts from DQ/DM.
// Returns BL8 read bursts on DQ/DQS, one beat per pad_ck.
// Optional feature macro: DRAM_RSP_BANK_CHK_EN enables open/closed bank tracking.
// Without the macro there is no bank state, and proto_err only reports bus spacing/overlap violations.
module dram_pad_responder #(
  parameter int DQ_BITS   = 8,
  parameter int DM_BITS   = 1,
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 14,
  parameter int COL_BITS  = 10,
  parameter int CL        = 5,
  parameter int CWL       = 5
) (
  input  logic                   pad_ck,
  input  logic                   pad_rst_n,
  input  logic                   pad_cke,
  input  logic                   pad_cs_n,
  input  logic                   pad_ras_n,
  input  logic                   pad_cas_n,
  input  logic                   pad_we_n,
  input  logic [BA_BITS-1:0]     pad_ba,
  input  logic [ADDR_BITS-1:0]   pad_addr,
  input  logic [DQ_BITS-1:0]     pad_dq_i,
  input  logic [DM_BITS-1:0]     pad_dm_i,
  output logic [DQ_BITS-1:0]     pad_dq_o,
  output logic                   pad_dq_oe,
  output logic                   pad_dqs_o,
  output logic                   pad_dqs_n_o,
  output logic                   pad_dqs_oe,
  output logic                   act_vld,
  output logic [BA_BITS-1:0]     act_ba,
  output logic [ADDR_BITS-1:0]   act_row,
  output logic                   rd_req,
  output logic [BA_BITS-1:0]     rd_ba,
  output logic [COL_BITS-1:0]    rd_col,
  input  logic [DQ_BITS*8-1:0]   rd_data,
  output logic                   wr_vld,
  output logic [BA_BITS-1:0]     wr_ba,
  output logic [COL_BITS-1:0]    wr_col,
  output logic [DQ_BITS*8-1:0]   wr_data,
  output logic [DM_BITS*8-1:0]   wr_mask,
  output logic                   proto_err
);

  localparam int DATA_W   = DQ_BITS * 8;
  localparam int MASK_W   = DM_BITS * 8;
  localparam int RD_DEPTH = CL - 1;
  // Bit i of a DQ occupancy map means "a beat is scheduled i cycles from now".
  localparam int MAP_W    = ((CL > CWL) ? CL : CWL) + 8;
  localparam logic [MAP_W-1:0] BURST  = MAP_W'(8'hFF);
  localparam logic [MAP_W-1:0] RD_WIN = BURST << CL;
  localparam logic [MAP_W-1:0] WR_WIN = BURST << CWL;

  logic [3:0] cmd;
  logic       is_act, is_rd, is_wr, is_pre;
  logic       rd_clash, wr_clash;
  logic       rd_bank_ok, wr_bank_ok, act_bank_ok;
  logic       rd_go, wr_go, act_go, cmd_err;

  logic [MAP_W-1:0] rd_map, wr_map;

  logic [RD_DEPTH-1:0]                rd_vld_q;
  logic [RD_DEPTH-1:0][BA_BITS-1:0]   rd_ba_q;
  logic [RD_DEPTH-1:0][COL_BITS-1:0]  rd_col_q;
  logic [CWL-1:0]                     wr_vld_q;
  logic [CWL-1:0][BA_BITS-1:0]        wr_ba_q;
  logic [CWL-1:0][COL_BITS-1:0]       wr_col_q;

  logic [DATA_W-1:0]   rd_sh;
  logic [2:0]          rd_cnt;
  logic                rd_load, rd_pre;

  logic                w_busy, w_start;
  logic [2:0]          wbeat;
  logic [BA_BITS-1:0]  cap_ba;
  logic [COL_BITS-1:0] cap_col;
  logic [DATA_W-1:0]   acc_data, acc_data_nxt;
  logic [MASK_W-1:0]   acc_mask, acc_mask_nxt;

  assign cmd = {pad_cs_n, pad_ras_n, pad_cas_n, pad_we_n};

  // Command decode; REF/MRS/NOP and cke-low all fall through to no action.
  always_comb begin
    is_act = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    is_pre = 1'b0;
    if (pad_cke) begin
      case (cmd)
        4'b0011: is_act = 1'b1;
        4'b0101: is_rd  = 1'b1;
        4'b0100: is_wr  = 1'b1;
        4'b0010: is_pre = 1'b1;
        default: ;
      endcase
    end
  end

  // Same-direction spacing under 8 and read/write overlap both show up as
  // a collision between the new burst window and the occupancy maps.
  assign rd_clash = |((rd_map | wr_map) & RD_WIN);
  assign wr_clash = |((rd_map | wr_map) & WR_WIN);

`ifdef DRAM_RSP_BANK_CHK_EN
  logic [2**BA_BITS-1:0] bank_open;

  assign rd_bank_ok  = bank_open[pad_ba];
  assign wr_bank_ok  = bank_open[pad_ba];
  assign act_bank_ok = ~bank_open[pad_ba];

  // Per-bank open state: ACT opens, PRE closes one bank or all when addr[10] is set.
  always_ff @(posedge pad_ck or negedge pad_rst_n) begin
    if (!pad_rst_n) begin
      bank_open <= '0;
    end else if (act_go) begin
      bank_open[pad_ba] <= 1'b1;
    end else if (is_pre) begin
      if (pad_addr[10]) bank_open <= '0;
      else              bank_open[pad_ba] <= 1'b0;
    end
  end
`else
  assign rd_bank_ok  = 1'b1;
  assign wr_bank_ok  = 1'b1;
  assign act_bank_ok = 1'b1;
`endif

  assign rd_go   = is_rd  & ~rd_clash & rd_bank_ok;
  assign wr_go   = is_wr  & ~wr_clash & wr_bank_ok;
  assign act_go  = is_act & act_bank_ok;
  assign cmd_err = (is_rd & ~rd_go) | (is_wr & ~wr_go) | (is_act & ~act_go);

  // Occupancy maps advance one cycle per clock; accepted bursts are inserted
  // one position lower, because the map is one cycle later when it is next read.
  always_ff @(posedge pad_ck or negedge pad_rst_n) begin
    if (!pad_rst_n) begin
      rd_map <= '0;
      wr_map <= '0;
    end else begin
      rd_map <= (rd_map >> 1) | (rd_go ? (RD_WIN >> 1) : '0);
      wr_map <= (wr_map >> 1) | (wr_go ? (WR_WIN >> 1) : '0);
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge pad_ck or negedge pad_rst_n) begin
    if (!pad_rst_n) proto_err <= 1'b0;
    else if (cmd_err) proto_err <= 1'b1;
  end

  // ACT report: one-cycle pulse with registered bank/row.
  always_ff @(posedge pad_ck or negedge pad_rst_n) begin
    if (!pad_rst_n) begin
      act_vld <= 1'b0;
      act_ba  <= '0;
      act_row <= '0;
    end else begin
      act_vld <= act_go;
      if (act_go) begin
        act_ba  <= pad_ba;
        act_row <= pad_addr;
      end
    end
  end

  // Read delay line; stage s is valid s+1 cycles after the RD command.
  always_ff @(posedge pad_ck or negedge pad_rst_n) begin
    if (!pad_rst_n) begin
      rd_vld_q <= '0;
      rd_ba_q  <= '0;
      rd_col_q <= '0;
    end else begin
      for (int s = RD_DEPTH - 1; s > 0; s--) begin
        rd_vld_q[s] <= rd_vld_q[s-1];
        rd_ba_q[s]  <= rd_ba_q[s-1];
        rd_col_q[s] <= rd_col_q[s-1];
      end
      rd_vld_q[0] <= rd_go;
      rd_ba_q[0]  <= rd_go ? pad_ba : '0;
      rd_col_q[0] <= rd_go ? pad_addr[COL_BITS-1:0] : '0;
    end
  end

  assign rd_req  = rd_vld_q[CL-3];
  assign rd_ba   = rd_ba_q[CL-3];
  assign rd_col  = rd_col_q[CL-3];
  assign rd_pre  = rd_vld_q[CL-3];
  assign rd_load = rd_vld_q[CL-2];

  // Read beat shifter and DQS generation. A back-to-back burst loads exactly
  // as the previous one finishes, so oe never drops and no second preamble appears.
  always_ff @(posedge pad_ck or negedge pad_rst_n) begin
    if (!pad_rst_n) begin
      rd_sh      <= '0;
      rd_cnt     <= '0;
      pad_dq_o   <= '0;
      pad_dq_oe  <= 1'b0;
      pad_dqs_o  <= 1'b0;
      pad_dqs_oe <= 1'b0;
    end else if (rd_load) begin
      pad_dq_o   <= rd_data[DQ_BITS-1:0];
      rd_sh      <= rd_data >> DQ_BITS;
      rd_cnt     <= 3'd7;
      pad_dq_oe  <= 1'b1;
      pad_dqs_o  <= 1'b1;
      pad_dqs_oe <= 1'b1;
    end else if (rd_cnt != 3'd0) begin
      pad_dq_o   <= rd_sh[DQ_BITS-1:0];
      rd_sh      <= rd_sh >> DQ_BITS;
      rd_cnt     <= rd_cnt - 3'd1;
      pad_dq_oe  <= 1'b1;
      pad_dqs_o  <= ~rd_cnt[0];
      pad_dqs_oe <= 1'b1;
    end else begin
      pad_dq_o   <= '0;
      pad_dq_oe  <= 1'b0;
      pad_dqs_o  <= 1'b0;
      pad_dqs_oe <= rd_pre;
    end
  end

  assign pad_dqs_n_o = ~pad_dqs_o;

  // Write delay line; the last stage marks the first data beat cycle.
  always_ff @(posedge pad_ck or negedge pad_rst_n) begin
    if (!pad_rst_n) begin
      wr_vld_q <= '0;
      wr_ba_q  <= '0;
      wr_col_q <= '0;
    end else begin
      for (int s = CWL - 1; s > 0; s--) begin
        wr_vld_q[s] <= wr_vld_q[s-1];
        wr_ba_q[s]  <= wr_ba_q[s-1];
        wr_col_q[s] <= wr_col_q[s-1];
      end
      wr_vld_q[0] <= wr_go;
      wr_ba_q[0]  <= wr_go ? pad_ba : '0;
      wr_col_q[0] <= wr_go ? pad_addr[COL_BITS-1:0] : '0;
    end
  end

  assign w_start = wr_vld_q[CWL-1];

  // Accumulator with the current beat merged in, so the final beat lands in the output directly.
  always_comb begin
    acc_data_nxt = acc_data;
    acc_mask_nxt = acc_mask;
    acc_data_nxt[wbeat*DQ_BITS +: DQ_BITS] = pad_dq_i;
    acc_mask_nxt[wbeat*DM_BITS +: DM_BITS] = pad_dm_i;
  end

  // Write beat capture; the completed burst is published with a one-cycle wr_vld pulse.
  always_ff @(posedge pad_ck or negedge pad_rst_n) begin
    if (!pad_rst_n) begin
      w_busy   <= 1'b0;
      wbeat    <= '0;
      cap_ba   <= '0;
      cap_col  <= '0;
      acc_data <= '0;
      acc_mask <= '0;
      wr_vld   <= 1'b0;
      wr_ba    <= '0;
      wr_col   <= '0;
      wr_data  <= '0;
      wr_mask  <= '0;
    end else begin
      wr_vld <= 1'b0;
      if (w_start) begin
        acc_data <= DATA_W'(pad_dq_i);
        acc_mask <= MASK_W'(pad_dm_i);
        wbeat    <= 3'd1;
        w_busy   <= 1'b1;
        cap_ba   <= wr_ba_q[CWL-1];
        cap_col  <= wr_col_q[CWL-1];
      end else if (w_busy) begin
        acc_data <= acc_data_nxt;
        acc_mask <= acc_mask_nxt;
        wbeat    <= wbeat + 3'd1;
        if (wbeat == 3'd7) begin
          w_busy  <= 1'b0;
          wr_vld  <= 1'b1;
          wr_data <= acc_data_nxt;
          wr_mask <= acc_mask_nxt;
          wr_ba   <= cap_ba;
          wr_col  <= cap_col;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_pad_responder.sv
// tb_dram_pad_responder: directed bench for dram_pad_responder.
// Each scenario runs 64 cycles after a fresh reset. Cycle c is the interval after the c-th clock edge
// following reset release. Commands are driven in cycle c and sampled at the edge that ends it.
// Set DRAM_RSP_BANK_CHK_EN to include the bank-state scenario.
module tb_dram_pad_responder;

  localparam int DQ_BITS = 8, DM_BITS = 1, BA_BITS = 3, ADDR_BITS = 14, COL_BITS = 10;
  localparam int CL = 5, CWL = 5;

  logic                  pad_ck, pad_rst_n, pad_cke;
  logic                  pad_cs_n, pad_ras_n, pad_cas_n, pad_we_n;
  logic [BA_BITS-1:0]    pad_ba;
  logic [ADDR_BITS-1:0]  pad_addr;
  logic [DQ_BITS-1:0]    pad_dq_i;
  logic [DM_BITS-1:0]    pad_dm_i;
  logic [DQ_BITS-1:0]    pad_dq_o;
  logic                  pad_dq_oe, pad_dqs_o, pad_dqs_n_o, pad_dqs_oe;
  logic                  act_vld;
  logic [BA_BITS-1:0]    act_ba;
  logic [ADDR_BITS-1:0]  act_row;
  logic                  rd_req;
  logic [BA_BITS-1:0]    rd_ba;
  logic [COL_BITS-1:0]   rd_col;
  logic [63:0]           rd_data;
  logic                  wr_vld;
  logic [BA_BITS-1:0]    wr_ba;
  logic [COL_BITS-1:0]   wr_col;
  logic [63:0]           wr_data;
  logic [7:0]            wr_mask;
  logic                  proto_err;

  dram_pad_responder #(
    .DQ_BITS(DQ_BITS), .DM_BITS(DM_BITS), .BA_BITS(BA_BITS), .ADDR_BITS(ADDR_BITS),
    .COL_BITS(COL_BITS), .CL(CL), .CWL(CWL)
  ) dut (
    .pad_ck(pad_ck), .pad_rst_n(pad_rst_n), .pad_cke(pad_cke),
    .pad_cs_n(pad_cs_n), .pad_ras_n(pad_ras_n), .pad_cas_n(pad_cas_n), .pad_we_n(pad_we_n),
    .pad_ba(pad_ba), .pad_addr(pad_addr), .pad_dq_i(pad_dq_i), .pad_dm_i(pad_dm_i),
    .pad_dq_o(pad_dq_o), .pad_dq_oe(pad_dq_oe), .pad_dqs_o(pad_dqs_o), .pad_dqs_n_o(pad_dqs_n_o),
    .pad_dqs_oe(pad_dqs_oe), .act_vld(act_vld), .act_ba(act_ba), .act_row(act_row),
    .rd_req(rd_req), .rd_ba(rd_ba), .rd_col(rd_col), .rd_data(rd_data),
    .wr_vld(wr_vld), .wr_ba(wr_ba), .wr_col(wr_col), .wr_data(wr_data), .wr_mask(wr_mask),
    .proto_err(proto_err)
  );

  initial pad_ck = 1'b0;
  always #5 pad_ck = ~pad_ck;

  int checks;
  int failures;

  logic [63:0]  tr_oe, tr_dqs_oe, tr_dqs, tr_dqs_n, tr_rdreq, tr_wrvld, tr_act;
  logic [127:0] beats;
  int           nbeats;
  logic         req_seen, data_due, got_req;
  logic [COL_BITS-1:0] req_col, data_col, first_col;
  logic [BA_BITS-1:0]  first_ba, wb, ab;
  logic [COL_BITS-1:0] wc;
  logic [63:0]  wd;
  logic [7:0]   wm;
  logic [ADDR_BITS-1:0] ar;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [3:0] pins, input logic [BA_BITS-1:0] ba,
                         input logic [ADDR_BITS-1:0] addr);
    {pad_cs_n, pad_ras_n, pad_cas_n, pad_we_n} = pins;
    pad_ba   = ba;
    pad_addr = addr;
  endtask

  task automatic sample(input int c);
    data_due = req_seen;
    data_col = req_col;
    req_seen = rd_req;
    req_col  = rd_col;
    if (rd_req && !got_req) begin
      got_req   = 1'b1;
      first_ba  = rd_ba;
      first_col = rd_col;
    end
    tr_oe[c]     = pad_dq_oe;
    tr_dqs_oe[c] = pad_dqs_oe;
    tr_dqs[c]    = pad_dqs_o;
    tr_dqs_n[c]  = pad_dqs_n_o;
    tr_rdreq[c]  = rd_req;
    tr_wrvld[c]  = wr_vld;
    tr_act[c]    = act_vld;
    if (pad_dq_oe && nbeats < 16) begin
      beats[nbeats*8 +: 8] = pad_dq_o;
      nbeats++;
    end
    if (wr_vld) begin
      wd = wr_data; wm = wr_mask; wb = wr_ba; wc = wr_col;
    end
    if (act_vld) begin
      ab = act_ba; ar = act_row;
    end
  endtask

  task automatic drive(input int id, input int c);
    int wstart;
    pad_cke  = 1'b1;
    set_cmd(4'b0111, '0, '0);
    pad_dq_i = 8'h55;
    pad_dm_i = 1'b0;
    wstart   = (id == 2) ? 25 : 17;
    case (id)
      1: begin
        if (c == 5)  set_cmd(4'b0011, 3'd3, 14'h1234);
        if (c == 10) set_cmd(4'b0101, 3'd2, 14'h0040);
      end
      2: begin
        if (c == 5) begin pad_cke = 1'b0; set_cmd(4'b0101, 3'd0, 14'h0010); end
        if (c == 20) set_cmd(4'b0100, 3'd1, 14'h0008);
      end
      3: begin
        if (c == 10) set_cmd(4'b0101, 3'd2, 14'h0040);
        if (c == 18) set_cmd(4'b0101, 3'd2, 14'h0048);
      end
      4: begin
        if (c == 10) set_cmd(4'b0101, 3'd2, 14'h0040);
        if (c == 14) set_cmd(4'b0101, 3'd2, 14'h0048);
      end
      5: begin
        if (c == 10) set_cmd(4'b0101, 3'd2, 14'h0040);
        if (c == 12) set_cmd(4'b0100, 3'd1, 14'h0008);
      end
      6: begin
        if (c == 10) set_cmd(4'b0101, 3'd2, 14'h0040);
      end
      7: begin
        if (c == 5)  set_cmd(4'b0101, 3'd4, 14'h0040);
        if (c == 8)  set_cmd(4'b0011, 3'd4, 14'h0100);
        if (c == 12) set_cmd(4'b0101, 3'd4, 14'h0040);
        if (c == 30) set_cmd(4'b0010, 3'd0, 14'h0400);
        if (c == 34) set_cmd(4'b0101, 3'd4, 14'h0048);
      end
      default: ;
    endcase
    if ((id == 2 || id == 5) && c >= wstart && c <= wstart + 7) begin
      pad_dq_i = 8'hA0 + 8'(c - wstart);
      pad_dm_i = (c == wstart + 3) ? 1'b1 : 1'b0;
    end
    if (data_due)
      rd_data = (data_col == 10'h040) ? 64'h0706050403020100 : 64'h1716151413121110;
    else
      rd_data = 64'hDEADBEEFCAFEF00D;
  endtask

  task automatic run_test(input int id);
    pad_rst_n = 1'b0;
    data_due = 1'b0; req_seen = 1'b0; got_req = 1'b0;
    req_col = '0; data_col = '0; first_col = '0; first_ba = '0;
    tr_oe = '0; tr_dqs_oe = '0; tr_dqs = '0; tr_dqs_n = '0;
    tr_rdreq = '0; tr_wrvld = '0; tr_act = '0;
    beats = '0; nbeats = 0;
    wd = '0; wm = '0; wb = '0; wc = '0; ab = '0; ar = '0;
    drive(0, 0);
    repeat (3) @(posedge pad_ck);
    #1 pad_rst_n = 1'b1;
    for (int c = 0; c < 64; c++) begin
      sample(c);
      if (c == 0)
        check($sformatf("t%0d_reset_state", id),
              64'({pad_dq_o, pad_dq_oe, pad_dqs_o, pad_dqs_n_o, pad_dqs_oe,
                   act_vld, rd_req, wr_vld, proto_err}), 64'h0020);
      if (id == 6 && c == 18) begin
        pad_rst_n = 1'b0;
        #1;
        check("t6_reset_outputs",
              64'({pad_dq_oe, pad_dqs_oe, pad_dqs_n_o, rd_req, wr_vld, proto_err}), 64'b001000);
      end
      if (id == 6 && c == 20) pad_rst_n = 1'b1;
      drive(id, c);
      @(posedge pad_ck);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pad_rst_n = 1'b0;
    data_due = 1'b0;
    data_col = '0;
    drive(0, 0);

    // single read plus an ACT report
    run_test(1);
    check("t1_act_trace", tr_act, 64'h40);
    check("t1_act_ba_row", 64'({ab, ar}), 64'({3'd3, 14'h1234}));
    check("t1_rdreq_trace", tr_rdreq, 64'h2000);
    check("t1_rd_ba_col", 64'({first_ba, first_col}), 64'({3'd2, 10'h040}));
    check("t1_dq_oe_trace", tr_oe, 64'h7F8000);
    check("t1_dqs_oe_trace", tr_dqs_oe, 64'h7FC000);
    check("t1_dqs_trace", tr_dqs, 64'h2A8000);
    check("t1_dqs_n_trace", tr_dqs_n, ~64'h2A8000);
    check("t1_beats", beats[63:0], 64'h0706050403020100);
    check("t1_nbeats", 64'(nbeats), 64'd8);
    check("t1_proto_err", 64'(proto_err), 64'd0);

    // write burst with one masked beat; a cke-low RD is ignored
    run_test(2);
    check("t2_wrvld_trace", tr_wrvld, 64'h2_0000_0000);
    check("t2_wr_data", wd, 64'hA7A6A5A4A3A2A1A0);
    check("t2_wr_mask", 64'(wm), 64'h08);
    check("t2_wr_ba_col", 64'({wb, wc}), 64'({3'd1, 10'h008}));
    check("t2_wr_data_held", wr_data, 64'hA7A6A5A4A3A2A1A0);
    check("t2_rdreq_none", tr_rdreq, 64'h0);
    check("t2_dq_oe_none", tr_oe, 64'h0);
    check("t2_proto_err", 64'(proto_err), 64'd0);

    // seamless reads 8 cycles apart
    run_test(3);
    check("t3_rdreq_trace", tr_rdreq, 64'h202000);
    check("t3_dq_oe_trace", tr_oe, 64'h7FFF8000);
    check("t3_dqs_oe_trace", tr_dqs_oe, 64'h7FFFC000);
    check("t3_dqs_trace", tr_dqs, 64'h2AAA8000);
    check("t3_beats_lo", beats[63:0], 64'h0706050403020100);
    check("t3_beats_hi", beats[127:64], 64'h1716151413121110);
    check("t3_proto_err", 64'(proto_err), 64'd0);

    // reads 4 cycles apart: second dropped
    run_test(4);
    check("t4_proto_err", 64'(proto_err), 64'd1);
    check("t4_rdreq_trace", tr_rdreq, 64'h2000);
    check("t4_dq_oe_trace", tr_oe, 64'h7F8000);
    check("t4_beats", beats[63:0], 64'h0706050403020100);

    // write overlapping a read on DQ: write dropped
    run_test(5);
    check("t5_proto_err", 64'(proto_err), 64'd1);
    check("t5_wrvld_none", tr_wrvld, 64'h0);
    check("t5_dq_oe_trace", tr_oe, 64'h7F8000);
    check("t5_beats", beats[63:0], 64'h0706050403020100);

    // reset asserted at read beat 3
    run_test(6);
    check("t6_dq_oe_trace", tr_oe, 64'h78000);
    check("t6_dqs_oe_trace", tr_dqs_oe, 64'h7C000);
    check("t6_dqs_trace", tr_dqs, 64'h28000);
    check("t6_rdreq_trace", tr_rdreq, 64'h2000);
    check("t6_wrvld_none", tr_wrvld, 64'h0);
    check("t6_proto_err", 64'(proto_err), 64'd0);

`ifdef DRAM_RSP_BANK_CHK_EN
    // bank state: closed-bank read rejected, ACT opens, PRE all closes
    run_test(7);
    check("t7_proto_err", 64'(proto_err), 64'd1);
    check("t7_act_trace", tr_act, 64'h200);
    check("t7_rdreq_trace", tr_rdreq, 64'h8000);
    check("t7_dq_oe_trace", tr_oe, 64'h1FE0000);
    check("t7_beats", beats[63:0], 64'h0706050403020100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
